reg_file_2r1w: RTL and testbench
================================

Name: reg_file_2r1w

Overview:
- Parametrised register file: one write port, two read ports, flip-flop storage.
- Generalises the single-bit, single-word storage cell to WIDTH x DEPTH.
- Read outputs are registered with valid flags.
- Entry 0 is hardwired to zero.
- Sits in the decode stage of the pipeline and feeds both ALU operand latches.

Parameters:
WIDTH, 16, data bits per entry
DEPTH, 16, number of entries (power of two, >= 2)
ADDR_W, 4, address width; must equal log2(DEPTH)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous active-high reset
wr_en  input  1  write request this cycle
wr_addr  input  ADDR_W  write entry index
wr_data  input  WIDTH  write data
rd_en1  input  1  read request, port 1
rd_addr1  input  ADDR_W  read entry index, port 1
rd_data1  output  WIDTH  registered read data, port 1
rd_valid1  output  1  rd_data1 updated from a read issued last cycle
rd_en2  input  1  read request, port 2
rd_addr2  input  ADDR_W  read entry index, port 2
rd_data2  output  WIDTH  registered read data, port 2
rd_valid2  output  1  rd_data2 updated from a read issued last cycle

Behaviour:
- Reset (rst high, asynchronous): clears immediately, independent of clk.
  - All DEPTH entries -> 0.
  - rd_data1, rd_data2 -> 0.
  - rd_valid1, rd_valid2 -> 0.
  - Inputs are ignored while rst is high.
  - First edge that can act is the first rising clk after rst deasserts.
- Reset mid-operation: in-flight reads are dropped (valid -> 0). A write in the same cycle as rst is discarded.
- Write, rising edge with wr_en=1:
  - mem[wr_addr] <= wr_data.
  - If wr_addr == 0, the write is dropped and entry 0 stays 0.
- Read port n (n = 1, 2), rising edge with rd_en_n=1:
  - rd_data_n <= mem[rd_addr_n].
  - rd_valid_n <= 1.
  - Latency is exactly one cycle.
- Read port n with rd_en_n=0:
  - rd_data_n holds its previous value.
  - rd_valid_n <= 0.
- Port independence:
  - Both ports may read the same or different addresses in the same cycle.
  - Ports never stall or block each other.
- rd_addr_n == 0 always returns 0.
- Write then read in later cycles: a write at edge k is visible to any read issued at edge k+1 or later.
- Same-cycle collision (wr_en=1, rd_en_n=1, wr_addr==rd_addr_n, address != 0): governed by the optional feature below.
- Address range: all 2^ADDR_W addresses are legal. No out-of-range case exists because ADDR_W = log2(DEPTH).
- No combinational path from any input to any output; all outputs come straight from flops.

Optional Feature:
- Macro: REG_FILE_BYPASS_EN
- Defined (write-before-read bypass):
  - On a same-cycle collision, rd_data_n <= wr_data, i.e. the new value, one cycle later.
  - Applies independently to each port.
  - Never applies to address 0, which returns 0.
- Undefined (read-before-write):
  - On a collision, rd_data_n <= the old mem content.
  - The new value is visible from the next read onward.
- Write behaviour and storage are identical in both builds.

Test Plan:
- Reset: assert rst for 2 cycles -> all rd_data = 0x0000 and rd_valid = 0. Then read addresses 1..15 on both ports -> 0x0000 with valid=1 one cycle later.
- Basic write/read: write 0xBEEF to addr 5; next cycle read addr 5 on port 1 and addr 5 on port 2 -> both rd_data = 0xBEEF, valid=1, one cycle after the read.
- Zero register: write 0x1234 to addr 0, then read addr 0 -> rd_data = 0x0000.
- Collision: addr 7 holds 0x1111. Same cycle: write 0x2222 to addr 7 and read addr 7 on port 1.
  - REG_FILE_BYPASS_EN defined -> 0x2222.
  - Undefined -> 0x1111.
  - Next read of addr 7 -> 0x2222 in both builds.
- Hold / valid: read addr 3 (holding 0xA5A5), then deassert rd_en1 for 3 cycles -> rd_data1 stays 0xA5A5 and rd_valid1 = 0 for those 3 cycles.
- Async reset mid-op: write 0xCAFE to addr 9 and issue a read on port 2. Pulse rst between clock edges -> rd_data2 = 0 and rd_valid2 = 0 immediately; a later read of addr 9 -> 0x0000.

Source files
------------

// File: rtl/reg_file_2r1w_if.sv
// Bus bundle for reg_file_2r1w: one write port, two registered read ports.
// The master drives requests and the slave (register file) returns read data.
interface reg_file_2r1w_if #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 4
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WIDTH-1:0]  wr_data;

    logic              rd_en1;
    logic [ADDR_W-1:0] rd_addr1;
    logic [WIDTH-1:0]  rd_data1;
    logic              rd_valid1;

    logic              rd_en2;
    logic [ADDR_W-1:0] rd_addr2;
    logic [WIDTH-1:0]  rd_data2;
    logic              rd_valid2;

    modport master (
        output wr_en, wr_addr, wr_data,
        output rd_en1, rd_addr1,
        output rd_en2, rd_addr2,
        input  rd_data1, rd_valid1,
        input  rd_data2, rd_valid2
    );

    modport slave (
        input  wr_en, wr_addr, wr_data,
        input  rd_en1, rd_addr1,
        input  rd_en2, rd_addr2,
        output rd_data1, rd_valid1,
        output rd_data2, rd_valid2
    );
endinterface

// File: rtl/reg_file_2r1w.sv
// 2-read/1-write flop register file with registered reads and zero entry 0.
// Define REG_FILE_BYPASS_EN for write-before-read bypass on same-cycle collisions.
module reg_file_2r1w #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input logic             clk,
    input logic             rst,
    reg_file_2r1w_if.slave  bus
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_next1;
    logic [WIDTH-1:0] rd_next2;
    logic             wr_ok;

    // Entry 0 is never written, so it keeps its reset value of zero.
    assign wr_ok = bus.wr_en && (bus.wr_addr != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_ok) begin
            mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    always_comb begin
        rd_next1 = mem[bus.rd_addr1];
        rd_next2 = mem[bus.rd_addr2];
`ifdef REG_FILE_BYPASS_EN
        if (wr_ok && (bus.wr_addr == bus.rd_addr1)) begin
            rd_next1 = bus.wr_data;
        end
        if (wr_ok && (bus.wr_addr == bus.rd_addr2)) begin
            rd_next2 = bus.wr_data;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.rd_data1  <= '0;
            bus.rd_valid1 <= 1'b0;
            bus.rd_data2  <= '0;
            bus.rd_valid2 <= 1'b0;
        end else begin
            bus.rd_valid1 <= bus.rd_en1;
            bus.rd_valid2 <= bus.rd_en2;
            if (bus.rd_en1) begin
                bus.rd_data1 <= rd_next1;
            end
            if (bus.rd_en2) begin
                bus.rd_data2 <= rd_next2;
            end
        end
    end
endmodule

// File: tb/tb_reg_file_2r1w.sv
// Directed self-checking bench for reg_file_2r1w.
// Expected values follow REG_FILE_BYPASS_EN for the collision case.
module tb_reg_file_2r1w;
    localparam int WIDTH  = 16;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_pass;

    reg_file_2r1w_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

    reg_file_2r1w #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wr_en    = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.rd_en1   = 1'b0;
        bus.rd_addr1 = '0;
        bus.rd_en2   = 1'b0;
        bus.rd_addr2 = '0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    task automatic rd(input logic e1, input logic [3:0] a1,
                      input logic e2, input logic [3:0] a2);
        bus.rd_en1   = e1;
        bus.rd_addr1 = a1;
        bus.rd_en2   = e2;
        bus.rd_addr2 = a2;
        tick();
        bus.rd_en1   = 1'b0;
        bus.rd_en2   = 1'b0;
    endtask

    logic [15:0] coll_exp;

    initial begin
        n_chk  = 0;
        n_pass = 0;
`ifdef REG_FILE_BYPASS_EN
        coll_exp = 16'h2222;
`else
        coll_exp = 16'h1111;
`endif
        idle();
        rst = 1'b1;
        // inputs active during reset must be ignored
        bus.wr_en   = 1'b1;
        bus.wr_addr = 4'd4;
        bus.wr_data = 16'h7777;
        bus.rd_en1  = 1'b1;
        bus.rd_en2  = 1'b1;
        tick();
        tick();
        chk("rst_d1", bus.rd_data1, 16'h0000);
        chk("rst_d2", bus.rd_data2, 16'h0000);
        chk("rst_v1", bus.rd_valid1, 1'b0);
        chk("rst_v2", bus.rd_valid2, 1'b0);
        idle();
        rst = 1'b0;
        tick();

        for (int a = 1; a < DEPTH; a++) begin
            rd(1'b1, a[3:0], 1'b1, a[3:0]);
            chk("rst_rd1", bus.rd_data1, 16'h0000);
            chk("rst_rd2", bus.rd_data2, 16'h0000);
            chk("rst_rv1", bus.rd_valid1, 1'b1);
            chk("rst_rv2", bus.rd_valid2, 1'b1);
        end
        tick();
        chk("idle_v1", bus.rd_valid1, 1'b0);

        wr(4'd5, 16'hBEEF);
        rd(1'b1, 4'd5, 1'b1, 4'd5);
        chk("basic_d1", bus.rd_data1, 16'hBEEF);
        chk("basic_d2", bus.rd_data2, 16'hBEEF);
        chk("basic_v1", bus.rd_valid1, 1'b1);
        chk("basic_v2", bus.rd_valid2, 1'b1);

        wr(4'd6, 16'h0F0F);
        rd(1'b1, 4'd5, 1'b1, 4'd6);
        chk("diff_d1", bus.rd_data1, 16'hBEEF);
        chk("diff_d2", bus.rd_data2, 16'h0F0F);

        wr(4'd0, 16'h1234);
        rd(1'b1, 4'd0, 1'b1, 4'd0);
        chk("zero_d1", bus.rd_data1, 16'h0000);
        chk("zero_d2", bus.rd_data2, 16'h0000);

        wr(4'd7, 16'h1111);
        bus.wr_en    = 1'b1;
        bus.wr_addr  = 4'd7;
        bus.wr_data  = 16'h2222;
        bus.rd_en1   = 1'b1;
        bus.rd_addr1 = 4'd7;
        bus.rd_en2   = 1'b1;
        bus.rd_addr2 = 4'd5;
        tick();
        bus.wr_en    = 1'b0;
        chk("coll_d1", bus.rd_data1, coll_exp);
        chk("coll_d2", bus.rd_data2, 16'hBEEF);
        rd(1'b1, 4'd7, 1'b1, 4'd7);
        chk("coll_after1", bus.rd_data1, 16'h2222);
        chk("coll_after2", bus.rd_data2, 16'h2222);

        // write to entry 0 colliding with a read of entry 0
        bus.wr_en    = 1'b1;
        bus.wr_addr  = 4'd0;
        bus.wr_data  = 16'h5555;
        bus.rd_en2   = 1'b1;
        bus.rd_addr2 = 4'd0;
        tick();
        idle();
        chk("coll_zero", bus.rd_data2, 16'h0000);

        wr(4'd3, 16'hA5A5);
        rd(1'b1, 4'd3, 1'b0, 4'd0);
        chk("hold_d1", bus.rd_data1, 16'hA5A5);
        chk("hold_v1", bus.rd_valid1, 1'b1);
        bus.rd_addr1 = 4'd5;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_keep", bus.rd_data1, 16'hA5A5);
            chk("hold_inv", bus.rd_valid1, 1'b0);
        end

        wr(4'd9, 16'hCAFE);
        rd(1'b0, 4'd0, 1'b1, 4'd9);
        chk("pre_rst_d2", bus.rd_data2, 16'hCAFE);
        chk("pre_rst_v2", bus.rd_valid2, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_d2", bus.rd_data2, 16'h0000);
        chk("arst_v2", bus.rd_valid2, 1'b0);
        chk("arst_d1", bus.rd_data1, 16'h0000);
        #1;
        rst = 1'b0;
        rd(1'b1, 4'd5, 1'b1, 4'd9);
        chk("post_rst9", bus.rd_data2, 16'h0000);
        chk("post_rst5", bus.rd_data1, 16'h0000);
        chk("post_rstv", bus.rd_valid2, 1'b1);
        rd(1'b1, 4'd4, 1'b0, 4'd0);
        chk("rst_wr_drop", bus.rd_data1, 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
